micro4_core: RTL and testbench

//  4-bit accumulator microprocessor with an internal 16x8 program store.
//  A 4-phase ring sequencer fetches, decodes and executes one instruction per 4 clocks.
//  A shared 4-bit data bus (digit1) links the registers; the output register (digit2) drives the display.
//  Top-level compute core; DataIn comes from switches.

---
 rtl/micro4_core.sv | 138 +++++++++++++
 tb/tb_micro4_core.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/micro4_core.sv
// micro4_core: 4-bit accumulator CPU, 16x8 program store, 4-phase fetch/decode/execute ring.
// Optional MICRO4_HALT_EN: opcode 1111 freezes the sequencer in T2 until MainClear.
module micro4_core #(
  parameter int DATA_W     = 4,
  parameter int PROG_DEPTH = 16
) (
  input  logic              MainClock,
  input  logic              MainClear,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              prog_we,
  input  logic [3:0]        prog_addr,
  input  logic [7:0]        prog_data,
  output logic [DATA_W-1:0] digit1,
  output logic [DATA_W-1:0] digit2
);

  localparam int AW = $clog2(PROG_DEPTH);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b0011;
  localparam logic [3:0] OP_IN   = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b0101;
`ifdef MICRO4_HALT_EN
  localparam logic [3:0] OP_HALT = 4'b1111;
`endif

  typedef enum logic [1:0] {PH_T0, PH_T1, PH_T2, PH_T3} phase_e;

  logic [7:0]        mem_q [PROG_DEPTH];
  phase_e            phase_q, phase_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] opnd;
  logic [7:0]        fetch_word;
  logic [3:0]        op;
  logic              halt_hit;

  // Ripple-carry add/subtract; subtraction adds ~b with carry-in 1, carry-out dropped.
  function automatic logic [DATA_W-1:0] alu_addsub(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              sub);
    logic [DATA_W-1:0] bx;
    logic [DATA_W-1:0] sum;
    logic              c;
    bx = sub ? ~b : b;
    c  = sub;
    for (int i = 0; i < DATA_W; i++) begin
      sum[i] = a[i] ^ bx[i] ^ c;
      c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    return sum;
  endfunction

  assign op         = ir_q[7:4];
  assign opnd       = DATA_W'(ir_q[3:0]);
  assign fetch_word = mem_q[pc_q];
  assign alu_res    = alu_addsub(a_q, b_q, op == OP_SUB);

`ifdef MICRO4_HALT_EN
  assign halt_hit = (phase_q == PH_T2) && (op == OP_HALT);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    bus     = '0;
    unique case (phase_q)
      PH_T0: begin
        ir_d    = fetch_word;
        bus     = DATA_W'(fetch_word[3:0]);
        phase_d = PH_T1;
      end
      PH_T1: begin
        pc_d    = pc_q + AW'(1);
        phase_d = PH_T2;
      end
      PH_T2: begin
        phase_d = halt_hit ? PH_T2 : PH_T3;
        case (op)
          OP_LOAD: begin a_d = opnd;     bus = opnd;   end
          OP_IN:   begin a_d = DataIn;   bus = DataIn; end
          OP_OUT:  begin out_d = a_q;    bus = a_q;    end
          OP_ADD,
          OP_SUB:  begin b_d = opnd;     bus = opnd;   end
          default: ;
        endcase
      end
      PH_T3: begin
        phase_d = PH_T0;
        if (op == OP_ADD || op == OP_SUB) begin
          a_d = alu_res;
          bus = alu_res;
        end
      end
      default: phase_d = PH_T0;
    endcase
    // Clear wins over any in-flight instruction and blanks the bus this cycle.
    if (MainClear) begin
      phase_d = PH_T0;
      pc_d    = '0;
      ir_d    = '0;
      a_d     = '0;
      b_d     = '0;
      out_d   = '0;
      bus     = '0;
    end
  end

  always_ff @(posedge MainClock) begin
    phase_q <= phase_d;
    pc_q    <= pc_d;
    ir_q    <= ir_d;
    a_q     <= a_d;
    b_q     <= b_d;
    out_q   <= out_d;
  end

  // Program store is never cleared; a same-edge fetch sees the old word.
  always_ff @(posedge MainClock) begin
    if (prog_we) mem_q[prog_addr[AW-1:0]] <= prog_data;
  end

  assign digit1 = bus;
  assign digit2 = out_q;

endmodule

// File: tb/tb_micro4_core.sv
// Directed self-checking bench for micro4_core; expected values hand-computed per program.
module tb_micro4_core;

  logic       MainClock;
  logic       MainClear;
  logic [3:0] DataIn;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] digit1;
  logic [3:0] digit2;

  logic [7:0] img [16];
  int checks;
  int errors;

  micro4_core #(.DATA_W(4), .PROG_DEPTH(16)) dut (
    .MainClock (MainClock),
    .MainClear (MainClear),
    .DataIn    (DataIn),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .digit1    (digit1),
    .digit2    (digit2)
  );

  initial MainClock = 1'b0;
  always #5 MainClock = ~MainClock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MainClock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Writes all 16 words while clear is held; core ends at T0, PC=0, clear still high.
  task automatic load_img();
    MainClear = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = img[i];
      tick(1);
    end
    prog_we = 1'b0;
    tick(1);
  endtask

  task automatic release_clear();
    MainClear = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    MainClear = 1'b1;
    DataIn    = 4'h0;
    prog_we   = 1'b0;
    prog_addr = 4'h0;
    prog_data = 8'h00;

    // IN then OUT
    img = '{default: 8'h00};
    img[0] = 8'h40; img[1] = 8'h30;
    DataIn = 4'hA;
    load_img();
    chk("rst_digit1", digit1, 4'h0);
    chk("rst_digit2", digit2, 4'h0);
    release_clear();
    tick(2);
    chk("in_t2_bus", digit1, 4'hA);
    tick(4);
    chk("out_t2_bus", digit1, 4'hA);
    chk("out_before", digit2, 4'h0);
    tick(2);
    chk("out_digit2", digit2, 4'hA);

    // LOAD 3, ADD 5, OUT, with a concurrent rewrite of word 1 during its fetch
    img = '{default: 8'h00};
    img[0] = 8'h53; img[1] = 8'h15; img[2] = 8'h30;
    load_img();
    chk("rst_bus_gated", digit1, 4'h0);
    chk("rst_clears_out", digit2, 4'h0);
    release_clear();
    chk("fetch_pc0", digit1, 4'h3);
    tick(4);
    chk("fetch_pc1", digit1, 4'h5);
    prog_we = 1'b1; prog_addr = 4'h1; prog_data = 8'h1A;
    tick(1);
    prog_we = 1'b0;
    tick(1);
    chk("add_t2_old_word", digit1, 4'h5);
    tick(1);
    chk("add_t3_alu", digit1, 4'h8);
    tick(3);
    chk("add_out_bus", digit1, 4'h8);
    tick(2);
    chk("add_digit2", digit2, 4'h8);

    // SUB wrap: 2-3 = F
    img = '{default: 8'h00};
    img[0] = 8'h52; img[1] = 8'h23; img[2] = 8'h30;
    load_img();
    release_clear();
    tick(7);
    chk("sub_t3_alu", digit1, 4'hF);
    tick(5);
    chk("sub_digit2", digit2, 4'hF);

    // ADD carry discarded: F+1 = 0, then 0+2 = 2
    img = '{default: 8'h00};
    img[0] = 8'h5F; img[1] = 8'h11; img[2] = 8'h30; img[3] = 8'h12; img[4] = 8'h30;
    load_img();
    release_clear();
    tick(6);
    chk("carry_t2_bus", digit1, 4'h1);
    tick(1);
    chk("carry_t3_alu", digit1, 4'h0);
    tick(5);
    chk("carry_digit2", digit2, 4'h0);
    tick(8);
    chk("carry_next_add", digit2, 4'h2);

    // NOPs and undefined opcodes, PC wrap, then clear during T1
    img = '{default: 8'h00};
    for (int i = 0; i < 16; i++)
      img[i] = {(i < 8) ? 4'h0 : 4'(i - 2), 4'(i)};
    DataIn = 4'h5;
    load_img();
    release_clear();
    chk("nop_fetch0", digit1, 4'h0);
    tick(2);
    chk("nop_t2_bus", digit1, 4'h0);
    tick(36);
    chk("undef_t2_bus", digit1, 4'h0);
    tick(22);
    chk("fetch_pc15", digit1, 4'hF);
    tick(4);
    chk("pc_wrap", digit1, 4'h0);
    tick(4);
    chk("rerun_pc1", digit1, 4'h1);
    chk("nop_digit2", digit2, 4'h0);
    tick(1);
    MainClear = 1'b1;
    tick(1);
    release_clear();
    chk("clr_t1_pc0", digit1, 4'h0);
    tick(4);
    chk("clr_t1_pc1", digit1, 4'h1);

    // Clear in the middle of LOAD T2
    img = '{default: 8'h00};
    img[0] = 8'h30; img[1] = 8'h57; img[2] = 8'h30; img[3] = 8'h59;
    load_img();
    release_clear();
    tick(12);
    chk("pre_clr_digit2", digit2, 4'h7);
    tick(2);
    chk("pre_clr_load_bus", digit1, 4'h9);
    MainClear = 1'b1;
    tick(1);
    release_clear();
    chk("post_clr_fetch0", digit1, 4'h0);
    tick(2);
    chk("post_clr_a_zero", digit1, 4'h0);
    tick(2);
    chk("post_clr_digit2", digit2, 4'h0);

    // Opcode 1111
    img = '{default: 8'h00};
    img[0] = 8'h53; img[1] = 8'hF0; img[2] = 8'h30;
    load_img();
    release_clear();
    tick(6);
    chk("f0_t2_bus", digit1, 4'h0);
`ifdef MICRO4_HALT_EN
    tick(20);
    chk("halt_bus", digit1, 4'h0);
    chk("halt_digit2", digit2, 4'h0);
    tick(1);
    chk("halt_still", digit1, 4'h0);
    MainClear = 1'b1;
    tick(1);
    release_clear();
    chk("halt_resume_fetch", digit1, 4'h3);
`else
    tick(6);
    chk("f0_nop_digit2", digit2, 4'h3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
